// File: rtl/bzmusic_pkg.sv
// Shared types and constants for the buzzer score sequencer.
// A score entry is {beat, tune}, with tune in the low bits.
package bzmusic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam int TUNE_LSB  = 0;
   localparam int REST_TUNE = 0;
   localparam int END_BEAT  = 0;

   function automatic int beat_lsb(input int tune_w);
      return TUNE_LSB + tune_w;
   endfunction

   // Minimum width of a counter that must hold the values 0..n-1.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bzmusic_beat_timer.sv
// Beat timer: a cycle divider wrapping every BEAT_DIV clocks and a beat down-counter.
// expire fires on the final clock of the final beat.
module bzmusic_beat_timer
   import bzmusic_pkg::*;
#(
   parameter int BEAT_W   = 4,
   parameter int BEAT_DIV = 12_500_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BEAT_W-1:0] beats,
   input  logic              hold,
   output logic              expire
);

   localparam int               DIV_W  = cnt_w(BEAT_DIV);
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BEAT_DIV - 1);

   logic [DIV_W-1:0]  div_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              div_wrap;

   assign div_wrap = !hold && (div_cnt == DIV_TC);
   assign expire   = div_wrap && (beat_cnt == BEAT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         beat_cnt <= '0;
      end else if (load) begin
         div_cnt  <= '0;
         beat_cnt <= beats;
      end else if (!hold) begin
         if (div_cnt == DIV_TC) begin
            div_cnt <= '0;
            if (beat_cnt != '0) beat_cnt <= beat_cnt - BEAT_W'(1);
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/bzmusic_seq.sv
// Buzzer score sequencer: walks a synchronous score ROM, times each note in beats,
// and drives a registered tune index and PWM enable.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ROM read in flight
// LOAD  | decode entry: note, loop reload or end of score
// PLAY  | note/rest sounding for beat*BEAT_DIV cycles
// GAP   | silent articulation gap of GAP_CYC cycles
module bzmusic_seq
   import bzmusic_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int TUNE_W   = 5,
   parameter int BEAT_W   = 4,
   parameter int BEAT_DIV = 12_500_000,
   parameter int GAP_CYC  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     pause,
   input  logic                     loop,
   input  logic [ADDR_W-1:0]        start_addr,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [BEAT_W+TUNE_W-1:0] rom_data,
   output logic [TUNE_W-1:0]        tune,
   output logic                     pwm_en,
   output logic                     busy,
   output logic                     done
);

   localparam int               BEAT_LSB = beat_lsb(TUNE_W);
   localparam int               GAP_W    = cnt_w(GAP_CYC);
   localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t            state, state_d;
   logic [ADDR_W-1:0] base, base_d, addr_d;
   logic [TUNE_W-1:0] tune_d;
   logic [GAP_W-1:0]  gap_cnt, gap_d;
   logic              first, first_d;
   logic              pwm_en_d, busy_d, done_d;
   logic [BEAT_W-1:0] beat_f;
   logic [TUNE_W-1:0] tune_f;
   logic              is_end, t_load, t_hold, t_expire;

   assign beat_f = rom_data[BEAT_LSB +: BEAT_W];
   assign tune_f = rom_data[TUNE_LSB +: TUNE_W];
   assign is_end = (beat_f == BEAT_W'(END_BEAT));
   assign t_load = (state == ST_LOAD) && !is_end;
   assign t_hold = pause || (state != ST_PLAY);

   bzmusic_beat_timer #(.BEAT_W(BEAT_W), .BEAT_DIV(BEAT_DIV)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (t_load),
      .beats  (beat_f),
      .hold   (t_hold),
      .expire (t_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rom_addr <= '0;
         base     <= '0;
         first    <= 1'b0;
         tune     <= '0;
         gap_cnt  <= '0;
         pwm_en   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         rom_addr <= addr_d;
         base     <= base_d;
         first    <= first_d;
         tune     <= tune_d;
         gap_cnt  <= gap_d;
         pwm_en   <= pwm_en_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
               if (!is_end)            state_d = ST_PLAY;
               else if (loop && !first) state_d = ST_FETCH;
               else                    state_d = ST_IDLE;
            end
            ST_PLAY:  if (t_expire) state_d = (GAP_CYC > 0) ? ST_GAP : ST_FETCH;
            ST_GAP:   if (!pause && gap_cnt == '0) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      addr_d  = rom_addr;
      base_d  = base;
      first_d = first;
      tune_d  = tune;
      gap_d   = gap_cnt;
      done_d  = 1'b0;
      if (!stop) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_d  = start_addr;
                  addr_d  = start_addr;
                  first_d = 1'b1;
               end
            end
            ST_LOAD: begin
               if (!is_end) begin
                  tune_d  = tune_f;
                  first_d = 1'b0;
               end else if (loop && !first) begin
                  addr_d  = base;
                  first_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
            ST_PLAY: begin
               if (t_expire) begin
                  if (GAP_CYC > 0) gap_d  = GAP_LD;
                  else             addr_d = rom_addr + ADDR_W'(1);
               end
            end
            ST_GAP: begin
               if (!pause) begin
                  if (gap_cnt == '0) addr_d = rom_addr + ADDR_W'(1);
                  else               gap_d  = gap_cnt - GAP_W'(1);
               end
            end
            default: ;
         endcase
      end
      if (state_d == ST_IDLE) tune_d = '0;
      pwm_en_d = (state_d == ST_PLAY) && (tune_d != TUNE_W'(REST_TUNE)) && !pause;
      busy_d   = (state_d != ST_IDLE);
   end

endmodule

// File: doc/bzmusic_seq.md
# bzmusic_seq

Parametrised buzzer score sequencer: fetches note entries from a synchronous score ROM, times each note in beat units, and drives the tune index plus enable to the tune PWM generator. Sits between the APB/register front-end (start/stop/pause/loop controls) and the tune PWM block. Adds to the earlier buzzer control FSM:

- configurable entry widths;
- an internal beat timer;
- rests;
- an inter-note articulation gap;
- pause;
- loop playback;
- programmable start address.

## Interface
- `ADDR_W`, default 8: score ROM address width.
- `TUNE_W`, default 5: tune index width. Tune 0 is a rest.
- `BEAT_W`, default 4: note length field width, in beats. Beat 0 is the end-of-score marker.
- `BEAT_DIV`, default 12_500_000: clk cycles per beat (≥2).
- `GAP_CYC`, default 0: silent cycles after every note. 0 means no gap state.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: single-cycle pulse; begins playback from `start_addr`. Ignored while `busy`.
- `stop` in 1: single-cycle pulse; aborts playback.
- `pause` in 1: level; freezes timing and silences output.
- `loop` in 1: level; sampled at the end marker.
- `start_addr` in `ADDR_W`: first entry address, captured on accepted `start`.
- `rom_addr` out `ADDR_W`: registered score ROM address.
- `rom_data` in `BEAT_W+TUNE_W`: entry `{beat, tune}`, valid the cycle after `rom_addr` is presented.
- `tune` out `TUNE_W`: current tune index to the PWM block.
- `pwm_en` out 1: PWM enable. High only in PLAY with tune≠0 and `pause`=0.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: single-cycle pulse on natural score completion.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- **IDLE**: an accepted `start` captures `start_addr` into `base` and `rom_addr`, sets `first`=1, and moves to FETCH.
- **FETCH**: one cycle, the ROM read in flight. Always moves to LOAD.
- **LOAD**: decodes `rom_data`.
  - beat≠0: latch `tune`, load beat counter = beat, clear the divider, clear `first`, go to PLAY.
  - beat=0 with `loop`=1 and `first`=0: set `rom_addr`=`base`, set `first`=1, go to FETCH.
  - beat=0 otherwise (including an empty score in loop mode): pulse `done`, go to IDLE.
- **PLAY**: the divider counts 0..`BEAT_DIV`-1. On its wrap the beat counter decrements. When the last beat expires:
  - `GAP_CYC`>0: go to GAP.
  - `GAP_CYC`=0: increment `rom_addr` and go to FETCH.
- **GAP**: `GAP_CYC` cycles with `pwm_en`=0 and `tune` held. Then increment `rom_addr` and go to FETCH.
- **Address arithmetic**: `rom_addr` increments modulo 2^`ADDR_W`; 2^`ADDR_W`-1 wraps to 0.
- **Pause**: while `pause`=1 in PLAY or GAP, both counters hold and `pwm_en`=0. Timing resumes exactly where it stopped. In FETCH and LOAD, `pause` takes effect at the next PLAY.
- **Stop**: highest priority. From any state, next cycle is IDLE with `tune`=0, `pwm_en`=0, `busy`=0, and no `done`. If `stop` and `start` arrive together, `stop` wins.
- **Reset**: state IDLE; `rom_addr`, `base` and `tune` = 0; `pwm_en`, `busy`, `done` and `first` = 0; counters = 0.

## Timing
- All outputs are registered.
- `start` accepted at edge N: `busy`=1 and `rom_addr`=`start_addr` from N+1 (FETCH); LOAD at N+2; first PLAY cycle at N+3 with `pwm_en` and `tune` valid.
- Note duration: exactly beat×`BEAT_DIV` PLAY cycles, then `GAP_CYC` GAP cycles. Fetch overhead is 2 cycles per note.
- `done` is asserted in the cycle after the LOAD that saw the end marker, together with `busy`=0.
- `rom_addr` changes only on leaving PLAY/GAP, on loop reload, or on `start`.

## Structure
- `bzmusic_pkg` holds:
  - state encoding enum;
  - field offset constants for the `{beat, tune}` entry;
  - the rest/end-marker value constants;
  - a `$clog2` helper width for the divider.
- Sub-module `bzmusic_beat_timer` contains the divider and beat down-counter.
  - Inputs: `load`, `beats`, `hold`.
  - Output: `expire` pulse, asserted on the last cycle of the last beat.
  - The sequencer FSM instantiates it once.

## Test plan
All scenarios use `BEAT_DIV`=4 and `GAP_CYC`=1 unless stated.
- **Basic score**: ROM[0]={2,5}, ROM[1]={1,0}, ROM[2]={0,x}; start with `start_addr`=0 → `tune`=5 with `pwm_en`=1 for 8 cycles; 1 gap cycle; `pwm_en`=0 for 4 rest cycles; `done` pulse once; `busy` falls the same cycle.
- **Loop**: same score with `loop`=1 → `rom_addr` sequence 0,1,2,0,1… with no `done`. Dropping `loop` → `done` after the next end marker. Score with ROM[start]={0,x} and `loop`=1 → immediate `done`, no spin.
- **Pause**: `pause` high for 10 cycles at PLAY cycle 3 of a 2-beat note → `pwm_en`=0 during the pause; note resumes and totals 8 PLAY cycles with `pwm_en`=1.
- **Stop and priority**: `stop` mid-note → IDLE next cycle, all outputs zero, no `done`. `start` and `stop` together in IDLE → remains IDLE. `start` while `busy` → ignored.
- **Wrap and gap**: `ADDR_W`=3, `start_addr`=7, ROM[7]={1,3}, ROM[0]={0,x} → `rom_addr` goes 7 then 0, then `done`. With `GAP_CYC`=0 → next FETCH directly after the last PLAY cycle.
- **Async reset**: `rst` asserted mid-PLAY, asynchronous to `clk` → outputs clear immediately; after release the block stays IDLE until the next `start`.
